// File: rtl/shift_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_cmd_sequencer
// Purpose  : Command-driven controller for a 4-bit shift register without an
//            enable. Accepts LOAD/SHR/SHL/ROL/ROR/HOLD commands over a
//            valid/ready handshake and expands each one into per-cycle
//            load/sel/ip drive values. A cycle-exact shadow copy of the
//            register is kept. While idle, the register is held by reloading
//            the shadow value.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   cmd_valid_i  : command present
//   cmd_ready_o  : command accepted on an edge with valid & ready
//   cmd_op_i     : 000 LOAD, 001 SHR, 010 SHL, 011 ROL, 100 ROR, 101 HOLD
//   cmd_data_i   : LOAD value
//   cmd_cnt_i    : repeat count for the repeat opcodes
//   sr_load_o    : register load
//   sr_sel_o     : register sel
//   sr_ip_o      : register parallel input
//   shadow_o     : mirror of the register contents
//   busy_o       : command executing (or queued commands pending)
//   done_o       : one-cycle pulse after a command's last register update
//   err_o        : one-cycle pulse when an illegal opcode is consumed
// Build option
//   SHSEQ_CMD_FIFO_EN : when defined, a FIFO_DEPTH-entry command FIFO sits in
//                       front of the sequencer and allows back-to-back
//                       execution with no idle cycle between commands.
// ============================================================================
module shift_cmd_sequencer #(
  parameter int CNT_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [3:0]       cmd_data_i,
  input  logic [CNT_W-1:0] cmd_cnt_i,
  output logic             sr_load_o,
  output logic [1:0]       sr_sel_o,
  output logic [3:0]       sr_ip_o,
  output logic [3:0]       shadow_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [2:0] c_OP_LOAD = 3'b000;
  localparam logic [2:0] c_OP_SHR  = 3'b001;
  localparam logic [2:0] c_OP_SHL  = 3'b010;
  localparam logic [2:0] c_OP_ROL  = 3'b011;
  localparam logic [2:0] c_OP_ROR  = 3'b100;
  localparam logic [2:0] c_OP_HOLD = 3'b101;

  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // An illegal depth has no meaningful FIFO; this marks the configuration
  // in the elaborated hierarchy so it is easy to spot.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_fifo_depth_illegal
  end

  // Next register value for a given drive; the shadow uses the exact same
  // function as the physical register so the two never drift apart.
  function automatic logic [3:0] f_sr_next(input logic [3:0] q,
                                           input logic       ld,
                                           input logic [1:0] sel,
                                           input logic [3:0] ip);
    logic [3:0] r;
    if (ld) begin
      r = ip;
    end else begin
      case (sel)
        2'b00:   r = {1'b0, q[3:1]};
        2'b01:   r = {q[2:0], 1'b0};
        2'b10:   r = {q[2:0], q[3]};
        default: r = {q[0], q[3:1]};
      endcase
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [3:0]       shadow_q, shadow_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sr_load_q, sr_load_d;
  logic [1:0]       sr_sel_q, sr_sel_d;
  logic [3:0]       sr_ip_q, sr_ip_d;

  logic             w_last;
  logic             w_take;
  logic [2:0]       w_src_op;
  logic [3:0]       w_src_data;
  logic [CNT_W-1:0] w_src_cnt;

  assign w_last = (state_q == ST_EXEC) && (rem_q == c_CNT_ONE);

`ifdef SHSEQ_CMD_FIFO_EN
  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_ENT_W = 7 + CNT_W;
  localparam logic [c_PTR_W:0] c_PTR_ONE = {{c_PTR_W{1'b0}}, 1'b1};

  logic [c_ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [c_PTR_W:0]   wr_ptr_q;
  logic [c_PTR_W:0]   rd_ptr_q;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign w_fifo_full  = (wr_ptr_q[c_PTR_W] != rd_ptr_q[c_PTR_W]) &&
                        (wr_ptr_q[c_PTR_W-1:0] == rd_ptr_q[c_PTR_W-1:0]);

  assign cmd_ready_o = rst_ni & ~w_fifo_full;
  assign w_push      = cmd_valid_i & cmd_ready_o;
  // Popping in the last EXEC cycle chains commands with no idle gap.
  assign w_take      = ~w_fifo_empty & ((state_q == ST_IDLE) | w_last);
  assign {w_src_op, w_src_data, w_src_cnt} = fifo_mem_q[rd_ptr_q[c_PTR_W-1:0]];
  assign busy_o      = (state_q == ST_EXEC) | ~w_fifo_empty;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q[c_PTR_W-1:0]] <= {cmd_op_i, cmd_data_i, cmd_cnt_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (w_take) rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
    end
  end
`else
  // Held low through reset even though the state register reads IDLE.
  assign cmd_ready_o = rst_ni & (state_q == ST_IDLE);
  assign w_take      = cmd_valid_i & (state_q == ST_IDLE);
  assign w_src_op    = cmd_op_i;
  assign w_src_data  = cmd_data_i;
  assign w_src_cnt   = cmd_cnt_i;
  assign busy_o      = (state_q == ST_EXEC);
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    shadow_d = f_sr_next(shadow_q, sr_load_q, sr_sel_q, sr_ip_q);

    if (state_q == ST_EXEC) begin
      rem_d = rem_q - c_CNT_ONE;
      if (w_last) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end

    if (w_take) begin
      if (w_src_op > c_OP_HOLD) begin
        // Illegal opcode: consumed and flagged, never executed.
        err_d = 1'b1;
      end else begin
        state_d = ST_EXEC;
        data_d  = w_src_data;
        if (w_src_op == c_OP_LOAD) begin
          op_d  = c_OP_LOAD;
          rem_d = c_CNT_ONE;
        end else if (w_src_cnt == c_CNT_ZERO) begin
          // A zero repeat count degenerates into a single hold cycle.
          op_d  = c_OP_HOLD;
          rem_d = c_CNT_ONE;
        end else begin
          op_d  = w_src_op;
          rem_d = w_src_cnt;
        end
      end
    end

    // Drive values are registered: decode from the next-cycle state so the
    // outputs line up with the cycle they apply to.
    sr_load_d = 1'b1;
    sr_sel_d  = 2'b00;
    sr_ip_d   = shadow_d;
    if (state_d == ST_EXEC) begin
      case (op_d)
        c_OP_LOAD: sr_ip_d = data_d;
        c_OP_SHR:  begin sr_load_d = 1'b0; sr_sel_d = 2'b00; end
        c_OP_SHL:  begin sr_load_d = 1'b0; sr_sel_d = 2'b01; end
        c_OP_ROL:  begin sr_load_d = 1'b0; sr_sel_d = 2'b10; end
        c_OP_ROR:  begin sr_load_d = 1'b0; sr_sel_d = 2'b11; end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      op_q      <= c_OP_HOLD;
      data_q    <= 4'b0000;
      rem_q     <= c_CNT_ZERO;
      shadow_q  <= 4'b0000;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sr_load_q <= 1'b1;
      sr_sel_q  <= 2'b00;
      sr_ip_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
      shadow_q  <= shadow_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sr_load_q <= sr_load_d;
      sr_sel_q  <= sr_sel_d;
      sr_ip_q   <= sr_ip_d;
    end
  end

  assign sr_load_o = sr_load_q;
  assign sr_sel_o  = sr_sel_q;
  assign sr_ip_o   = sr_ip_q;
  assign shadow_o  = shadow_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_cmd_sequencer
// Purpose  : Self-checking bench for shift_cmd_sequencer. Each accepted
//            command pushes its expected per-cycle drive values, done and err
//            pulses into scoreboard queues tagged with the cycle they must
//            appear in; a negedge monitor pops and compares them. A model of
//            the downstream register, fed by the drive outputs, is compared
//            against shadow every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_shift_cmd_sequencer;

  localparam int CNT_W = 4;
`ifdef SHSEQ_CMD_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready_o;
  logic [2:0]       cmd_op;
  logic [3:0]       cmd_data;
  logic [CNT_W-1:0] cmd_cnt;
  logic             sr_load_o;
  logic [1:0]       sr_sel_o;
  logic [3:0]       sr_ip_o;
  logic [3:0]       shadow_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  shift_cmd_sequencer #(.CNT_W(CNT_W), .FIFO_DEPTH(4)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op),
    .cmd_data_i  (cmd_data),
    .cmd_cnt_i   (cmd_cnt),
    .sr_load_o   (sr_load_o),
    .sr_sel_o    (sr_sel_o),
    .sr_ip_o     (sr_ip_o),
    .shadow_o    (shadow_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       ld;
    logic       sel_chk;
    logic [1:0] sel;
    logic       ip_chk;
    logic [3:0] ip;
    logic [3:0] sh_before;
    logic [3:0] sh_after;
  } exp_t;

  exp_t exp_q [$];
  int   done_q [$];
  int   err_q [$];

  int         n_chk;
  int         n_err;
  int         cyc;
  int         next_free;
  logic [3:0] p_sh;     // planned shadow after all issued commands
  logic [3:0] cur_sh;   // expected shadow in the current idle cycle
  logic [3:0] reg_m;    // model of the downstream shift register
  logic       mon_en;
  exp_t       mon_e;
  logic       exp_pulse;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] reg_next(input logic [3:0] q, input logic ld,
                                          input logic [1:0] sel, input logic [3:0] ip);
    if (ld) return ip;
    case (sel)
      2'b00:   return {1'b0, q[3:1]};
      2'b01:   return {q[2:0], 1'b0};
      2'b10:   return {q[2:0], q[3]};
      default: return {q[0], q[3:1]};
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_m <= 4'b0000;
    else        reg_m <= reg_next(reg_m, sr_load_o, sr_sel_o, sr_ip_o);
  end

  // Expected activity for a command accepted at the edge that makes cyc==acc.
  task automatic plan(input logic [2:0] op, input logic [3:0] d, input logic [3:0] cnt, input int acc);
    int   start;
    int   n;
    exp_t e;
    start = (acc + LAT > next_free) ? acc + LAT : next_free;
    if (op > 3'd5) begin
      err_q.push_back(start);
      next_free = start + 1;
      return;
    end
    n = (op == 3'd0 || cnt == 0) ? 1 : int'(cnt);
    for (int i = 0; i < n; i++) begin
      e.cyc       = start + i;
      e.sh_before = p_sh;
      e.ip_chk    = 1'b0;
      e.ip        = 4'b0000;
      e.sel_chk   = 1'b1;
      e.sel       = 2'b00;
      e.ld        = 1'b0;
      if (op == 3'd0) begin
        e.ld = 1'b1; e.sel_chk = 1'b0; e.ip_chk = 1'b1; e.ip = d;
        p_sh = d;
      end else if (op == 3'd5 || cnt == 0) begin
        e.ld = 1'b1; e.ip_chk = 1'b1; e.ip = p_sh;
      end else begin
        case (op)
          3'd1:    e.sel = 2'b00;
          3'd2:    e.sel = 2'b01;
          3'd3:    e.sel = 2'b10;
          default: e.sel = 2'b11;
        endcase
        p_sh = reg_next(p_sh, 1'b0, e.sel, 4'b0000);
      end
      e.sh_after = p_sh;
      exp_q.push_back(e);
    end
    done_q.push_back(start + n);
    next_free = start + n;
  endtask

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge
  // with cmd_valid still high so commands can be pushed back to back.
  task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [3:0] cnt);
    int w;
    w = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_cnt = cnt;
    while (!cmd_ready_o && w < 300) begin
      @(posedge clk); #1; w++;
    end
    if (!cmd_ready_o) begin
      check_eq("ready_timeout", 32'(cmd_ready_o), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    plan(op, d, cnt, cyc + 1);
    @(posedge clk); #1;
  endtask

  task automatic issue1(input logic [2:0] op, input logic [3:0] d, input logic [3:0] cnt);
    issue(op, d, cnt);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || err_q.size() != 0) && w < 500) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 500) check_eq("idle_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check_eq("sb_reg_shadow", 32'(shadow_o), 32'(reg_m));
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        check_eq("exec_slot_missed", 32'(cyc), 32'(exp_q[0].cyc));
        mon_e = exp_q.pop_front();
      end
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        check_eq("busy_exec", 32'(busy_o), 32'd1);
        check_eq("exec_load", 32'(sr_load_o), 32'(mon_e.ld));
        if (mon_e.sel_chk) check_eq("exec_sel", 32'(sr_sel_o), 32'(mon_e.sel));
        if (mon_e.ip_chk)  check_eq("exec_ip", 32'(sr_ip_o), 32'(mon_e.ip));
        check_eq("exec_shadow", 32'(shadow_o), 32'(mon_e.sh_before));
        cur_sh = mon_e.sh_after;
      end else begin
`ifndef SHSEQ_CMD_FIFO_EN
        check_eq("busy_idle", 32'(busy_o), 32'd0);
`endif
        check_eq("idle_load", 32'(sr_load_o), 32'd1);
        check_eq("idle_sel", 32'(sr_sel_o), 32'd0);
        check_eq("idle_ip", 32'(sr_ip_o), 32'(cur_sh));
        check_eq("idle_shadow", 32'(shadow_o), 32'(cur_sh));
      end
      while (done_q.size() != 0 && done_q[0] < cyc) begin
        check_eq("done_missed", 32'(cyc), 32'(done_q[0]));
        void'(done_q.pop_front());
      end
      exp_pulse = (done_q.size() != 0 && done_q[0] == cyc);
      if (exp_pulse) void'(done_q.pop_front());
      check_eq("done", 32'(done_o), 32'(exp_pulse));
      while (err_q.size() != 0 && err_q[0] < cyc) begin
        check_eq("err_missed", 32'(cyc), 32'(err_q[0]));
        void'(err_q.pop_front());
      end
      exp_pulse = (err_q.size() != 0 && err_q[0] == cyc);
      if (exp_pulse) void'(err_q.pop_front());
      check_eq("err", 32'(err_o), 32'(exp_pulse));
    end
  end

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_sr_load"}, 32'(sr_load_o), 32'd1);
    check_eq({pfx, "_sr_sel"}, 32'(sr_sel_o), 32'd0);
    check_eq({pfx, "_sr_ip"}, 32'(sr_ip_o), 32'd0);
    check_eq({pfx, "_shadow"}, 32'(shadow_o), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy_o), 32'd0);
    check_eq({pfx, "_done"}, 32'(done_o), 32'd0);
    check_eq({pfx, "_err"}, 32'(err_o), 32'd0);
    check_eq({pfx, "_ready"}, 32'(cmd_ready_o), 32'd0);
  endtask

  task automatic clear_model();
    exp_q.delete(); done_q.delete(); err_q.delete();
    p_sh = 4'b0000; cur_sh = 4'b0000; next_free = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; mon_en = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0; cmd_cnt = '0;
    clear_model();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // LOAD, then ROL x3 from 1011
    issue1(3'd0, 4'b1011, 4'd0); wait_idle();
    check_eq("load_final", 32'(shadow_o), 32'hB);
    issue1(3'd3, 4'b0000, 4'd3); wait_idle();
    check_eq("rol_final", 32'(shadow_o), 32'hD);

    // SHR x5 from 1000 runs past empty
    issue1(3'd0, 4'b1000, 4'd0);
    issue1(3'd1, 4'b0000, 4'd5); wait_idle();
    check_eq("shr_final", 32'(shadow_o), 32'h0);

    // illegal opcodes leave shadow alone; zero count is one hold cycle
    issue1(3'd0, 4'b0110, 4'd0);
    issue1(3'd6, 4'b1111, 4'd3);
    issue1(3'd7, 4'b0001, 4'd1); wait_idle();
    check_eq("illegal_shadow", 32'(shadow_o), 32'h6);
    issue1(3'd2, 4'b0000, 4'd0); wait_idle();
    check_eq("shl0_shadow", 32'(shadow_o), 32'h6);
    issue1(3'd2, 4'b0000, 4'd2); wait_idle();
    check_eq("shl2_final", 32'(shadow_o), 32'h8);
    issue1(3'd4, 4'b0000, 4'd2);
    issue1(3'd5, 4'b0000, 4'd3);
    issue1(3'd4, 4'b0000, 4'd15); wait_idle();
    check_eq("ror_hold_final", 32'(shadow_o), 32'h4);

    // random mix
    for (int i = 0; i < 16; i++) begin
      issue1(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 4)));
    end
    wait_idle();

    // reset in the third cycle of ROR x8
    issue1(3'd0, 4'b1011, 4'd0); wait_idle();
    issue1(3'd4, 4'b0000, 4'd8);
    @(posedge clk); #1;
    @(posedge clk); #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    check_eq("post_rst_shadow", 32'(shadow_o), 32'h0);
    issue1(3'd0, 4'b0101, 4'd0); wait_idle();
    check_eq("post_rst_load", 32'(shadow_o), 32'h5);

`ifdef SHSEQ_CMD_FIFO_EN
    // fill the FIFO behind a long command; execution must chain with no gap
    issue(3'd4, 4'b0000, 4'd8);
    issue(3'd1, 4'b0000, 4'd1);
    issue(3'd0, 4'b1001, 4'd0);
    issue(3'd3, 4'b0000, 4'd2);
    issue(3'd5, 4'b0000, 4'd0);
    check_eq("fifo_full_ready", 32'(cmd_ready_o), 32'd0);
    issue(3'd6, 4'b0000, 4'd1);
    issue(3'd2, 4'b0000, 4'd1);
    cmd_valid = 1'b0;
    wait_idle();
    check_eq("fifo_final", 32'(shadow_o), 32'hC);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
